// File: rtl/aes_encrypt_iter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : aes_encrypt_iter                                            |
// | Purpose  : Iterative AES encryptor, one full round per clock, using    |
// |            16 combinational S-boxes and 4 MixColumns column units.     |
// |            Reads a precomputed key schedule and follows the           |
// |            START/DONE level handshake.                                 |
// | Ports    : CLK, RESET_N (sync, active-low)                             |
// |            AES_START      level request to encrypt                     |
// |            AES_MSG        plaintext, byte k = bits [8k:8k+7]           |
// |            AES_KEY_SCHED  round key r = bits [128r:128r+127]           |
// |            AES_MSG_ENC    ciphertext register                          |
// |            AES_DONE       result valid                                 |
// |            AES_BUSY       high while rounds are in progress            |
// |            DBG_STATE/DBG_ROUND  only with AES_ENC_ROUND_TAP_EN         |
// | Options  : `define AES_ENC_ROUND_TAP_EN adds the round-tap outputs.    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module aes_encrypt_iter #(
  parameter int NUM_ROUNDS = 10,
  localparam int KS_W = 128 * (NUM_ROUNDS + 1)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            AES_START,
  input  logic [0:127]    AES_MSG,
  input  logic [0:KS_W-1] AES_KEY_SCHED,
  output logic [0:127]    AES_MSG_ENC,
  output logic            AES_DONE,
  output logic            AES_BUSY
`ifdef AES_ENC_ROUND_TAP_EN
  ,
  output logic [0:127]    DBG_STATE,
  output logic [3:0]      DBG_ROUND
`endif
);

  generate
    if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
      $error("aes_encrypt_iter: NUM_ROUNDS must be 10, 12 or 14");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] LAST_MID_RND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] MAX_RND      = 4'(NUM_ROUNDS);

  // Forward S-box, entry b at bits [8b:8b+7].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  // Multiply by 02 in GF(2^8) mod 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]   fsm_q,   fsm_d;
  logic [3:0]   rnd_q,   rnd_d;
  logic [0:127] state_q, state_d;
  logic [0:127] enc_q,   enc_d;
  logic         done_q,  done_d;

  logic [0:127] w_sub;
  logic [0:127] w_shr;
  logic [0:127] w_mix;
  logic [0:127] w_rk0;
  logic [0:127] w_rk_rnd;
  logic [0:127] w_rk_last;

  // Round key selects; {rnd_q, 7'd0} is 128*rnd at exactly the index width.
  assign w_rk0     = AES_KEY_SCHED[0 +: 128];
  assign w_rk_rnd  = AES_KEY_SCHED[{rnd_q, 7'd0} +: 128];
  assign w_rk_last = AES_KEY_SCHED[128*NUM_ROUNDS +: 128];

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign w_sub[8*gi +: 8] = sbox(state_q[8*gi +: 8]);
  end

  // Byte (row r, col c) sits at index 4c+r; row r takes from column c+r.
  for (genvar gc = 0; gc < 4; gc++) begin : g_shift_col
    for (genvar gr = 0; gr < 4; gr++) begin : g_shift_row
      assign w_shr[8*(4*gc+gr) +: 8] = w_sub[8*(4*((gc+gr)%4)+gr) +: 8];
    end
  end

  for (genvar gc = 0; gc < 4; gc++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = w_shr[32*gc      +: 8];
    assign a1 = w_shr[32*gc + 8  +: 8];
    assign a2 = w_shr[32*gc + 16 +: 8];
    assign a3 = w_shr[32*gc + 24 +: 8];
    // 03*x is computed as xtime(x) ^ x.
    assign w_mix[32*gc      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign w_mix[32*gc + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign w_mix[32*gc + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign w_mix[32*gc + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    enc_d   = enc_q;
    done_d  = done_q;
    case (fsm_q)
      ST_IDLE: begin
        if (AES_START) begin
          state_d = AES_MSG ^ w_rk0;
          rnd_d   = 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = w_mix ^ w_rk_rnd;
        if (rnd_q < MAX_RND) begin
          rnd_d = rnd_q + 4'd1;
        end
        if (rnd_q == LAST_MID_RND) begin
          fsm_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        enc_d  = w_shr ^ w_rk_last;
        done_d = 1'b1;
        fsm_d  = ST_DONE;
      end
      ST_DONE: begin
        // DONE is a level that lasts until the requester withdraws START.
        if (!AES_START) begin
          done_d = 1'b0;
          rnd_d  = 4'd0;
          fsm_d  = ST_IDLE;
        end
      end
      default: begin
        fsm_d  = ST_IDLE;
        rnd_d  = 4'd0;
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
      enc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
    end
  end

  assign AES_MSG_ENC = enc_q;
  assign AES_DONE    = done_q;
  assign AES_BUSY    = (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);

`ifdef AES_ENC_ROUND_TAP_EN
  assign DBG_STATE = state_q;
  assign DBG_ROUND = rnd_q;
`endif

endmodule
`default_nettype wire
